// File: rtl/tetris_pkg.sv
// Shared board geometry, piece encodings, FSM states and spawn footprints
// used by the movement and line-clear stages.
package tetris_pkg;
  localparam int ROWS      = 8;
  localparam int COLS      = 4;
  localparam int SPAWN_LOC = 5;

  typedef enum logic [1:0] {
    PC_DOT    = 2'b00,
    PC_BAR    = 2'b01,
    PC_SQUARE = 2'b10,
    PC_L      = 2'b11
  } piece_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SPAWN = 3'd3,
    ST_DONE  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  // Cells occupied by a piece of type t at SPAWN_LOC with rotation 0.
  function automatic logic [ROWS*COLS-1:0] footprint(input logic [1:0] t);
    logic [ROWS*COLS-1:0] f;
    f = '0;
    f[SPAWN_LOC] = 1'b1;
    case (t)
      PC_BAR:    f[SPAWN_LOC-COLS] = 1'b1;
      PC_SQUARE: begin
        f[SPAWN_LOC+1]      = 1'b1;
        f[SPAWN_LOC-COLS]   = 1'b1;
        f[SPAWN_LOC-COLS+1] = 1'b1;
      end
      PC_L: begin
        f[SPAWN_LOC+1]    = 1'b1;
        f[SPAWN_LOC-COLS] = 1'b1;
      end
      default: ;
    endcase
    return f;
  endfunction
endpackage

// File: rtl/piece_lfsr.sv
// 4-bit Fibonacci LFSR that picks the next piece type.
module piece_lfsr #(
  parameter logic [3:0] SEED = 4'b1001
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       advance_i,
  output logic [3:0] lfsr_o
);
  logic [3:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_i) lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  always_ff @(posedge clka or posedge restart)
    if (restart) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;

  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/line_clear.sv
// Clears full rows of a landed board, compacts the rows above, then spawns
// the next piece or declares game over.
module line_clear #(
  parameter int         ROWS      = tetris_pkg::ROWS,
  parameter int         COLS      = tetris_pkg::COLS,
  parameter logic [3:0] LFSR_SEED = 4'b1001
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 touched,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic [ROWS*COLS-1:0] board_out,
  output logic                 board_valid,
  output logic                 busy,
  output logic [1:0]           spawn_type,
  output logic [7:0]           lines,
  output logic                 game_over
);
  import tetris_pkg::*;

  localparam int W  = ROWS*COLS;
  localparam int PW = $clog2(ROWS);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    work_q, work_d, bout_q, bout_d, shifted;
  logic [7:0]      lines_q, lines_d;
  logic [1:0]      spawn_q, spawn_d;
  logic            valid_q, valid_d, over_q, over_d;
  logic            advance, row_full, shifted_full;
  logic [3:0]      lfsr;

  piece_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clka      (clka),
    .restart   (restart),
    .advance_i (advance),
    .lfsr_o    (lfsr)
  );

  // Rows 1..ptr take the row above, row 0 empties, rows below ptr keep.
  always_comb begin
    shifted = work_q << COLS;
    for (int r = 0; r < ROWS; r++)
      if (r > int'(ptr_q)) shifted[r*COLS +: COLS] = work_q[r*COLS +: COLS];
  end

  assign row_full     = &work_q[int'(ptr_q)*COLS +: COLS];
  assign shifted_full = &shifted[int'(ptr_q)*COLS +: COLS];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    work_d  = work_q;
    lines_d = lines_q;
    bout_d  = bout_q;
    spawn_d = spawn_q;
    over_d  = over_q;
    valid_d = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: if (touched) begin
        work_d  = board_in;
        ptr_d   = PW'(ROWS-1);
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (row_full)        state_d = ST_SHIFT;
        else if (ptr_q == 0) state_d = ST_SPAWN;
        else                 ptr_d   = ptr_q - 1'b1;
      end
      // The row dropped into ptr is tested in the same cycle, so every
      // cleared row costs exactly one extra cycle.
      ST_SHIFT: begin
        work_d = shifted;
        if (lines_q != 8'hFF) lines_d = lines_q + 8'd1;
        if (!shifted_full) begin
          if (ptr_q == 0) state_d = ST_SPAWN;
          else begin
            ptr_d   = ptr_q - 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_SPAWN: begin
        valid_d = 1'b1;
        if (|(work_q & footprint(PC_SQUARE))) begin
          over_d  = 1'b1;
          bout_d  = work_q;
          state_d = ST_OVER;
        end else begin
          spawn_d = lfsr[1:0];
          bout_d  = work_q | footprint(lfsr[1:0]);
          advance = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_OVER: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge restart)
    if (restart) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      work_q  <= '0;
      lines_q <= '0;
      bout_q  <= '0;
      spawn_q <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      work_q  <= work_d;
      lines_q <= lines_d;
      bout_q  <= bout_d;
      spawn_q <= spawn_d;
      valid_q <= valid_d;
      over_q  <= over_d;
    end

  assign board_out   = bout_q;
  assign board_valid = valid_q;
  assign busy        = (state_q == ST_SCAN) || (state_q == ST_SHIFT) || (state_q == ST_SPAWN);
  assign spawn_type  = spawn_q;
  assign lines       = lines_q;
  assign game_over   = over_q;
endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear with a result scoreboard.
module tb_line_clear;
  logic        clka = 1'b0;
  logic        restart, touched;
  logic [31:0] board_in, board_out;
  logic        board_valid, busy, game_over;
  logic [1:0]  spawn_type;
  logic [7:0]  lines;

  line_clear dut (
    .clka(clka), .restart(restart), .touched(touched), .board_in(board_in),
    .board_out(board_out), .board_valid(board_valid), .busy(busy),
    .spawn_type(spawn_type), .lines(lines), .game_over(game_over)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [31:0] board;
    logic [1:0]  typ;
    logic [7:0]  lines;
    logic        go;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  logic [3:0] lfsr_m;
  logic [1:0] type_m;
  int         lines_m;

  function automatic logic [31:0] fp(input logic [1:0] t);
    case (t)
      2'b00:   return 32'h0000_0020;
      2'b01:   return 32'h0000_0022;
      2'b10:   return 32'h0000_0066;
      default: return 32'h0000_0062;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clka);
    restart = 1'b1; touched = 1'b0; board_in = '0;
    repeat (2) @(negedge clka);
    restart = 1'b0;
    lfsr_m = 4'b1001; type_m = 2'b00; lines_m = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_board"}, board_out, 32'h0);
    check({tag, "_valid"}, board_valid, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_type"},  spawn_type, 0);
    check({tag, "_lines"}, lines, 0);
    check({tag, "_go"},    game_over, 0);
  endtask

  // cleared: board after all row clears; nclr: rows cleared; go: expect game over
  task automatic run(input string tag, input logic [31:0] b, input logic [31:0] cleared,
                     input int nclr, input bit go);
    exp_t e;
    int   n;
    bit   got;
    if (go) e.board = cleared;
    else begin
      type_m  = lfsr_m[1:0];
      lfsr_m  = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
      e.board = cleared | fp(type_m);
    end
    lines_m = (lines_m + nclr > 255) ? 255 : lines_m + nclr;
    e.typ = type_m; e.lines = 8'(lines_m); e.go = go; e.lat = 10 + nclr;
    sb.push_back(e);

    @(negedge clka);
    board_in = b; touched = 1'b1;
    @(posedge clka);
    #1 touched = 1'b0; board_in = '0;
    n = 1; got = 0;
    while (n <= 40) begin
      @(negedge clka);
      if (n == 1) check({tag, "_busy"}, busy, 1);
      if (board_valid) begin got = 1; break; end
      n++;
    end
    check({tag, "_valid_seen"}, got, 1);
    e = sb.pop_front();
    if (got) begin
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_board"},   board_out, e.board);
      check({tag, "_type"},    spawn_type, e.typ);
      check({tag, "_lines"},   lines, e.lines);
      check({tag, "_go"},      game_over, e.go);
      @(negedge clka);
      check({tag, "_pulse"},   board_valid, 0);
    end
  endtask

  initial begin
    int cnt, n;
    restart = 1'b1; touched = 1'b0; board_in = '0;
    #1 check_zero("por");
    do_reset();
    check_zero("reset");

    run("empty", 32'h0000_0000, 32'h0000_0000, 0, 0);
    check("empty_plan_board", board_out, 32'h0000_0022);

    do_reset();
    run("row7", 32'hF100_0000, 32'h1000_0000, 1, 0);
    check("row7_plan_board", board_out, 32'h1000_0022);

    do_reset();
    run("three", 32'hFF0F_0000, 32'h0000_0000, 3, 0);
    check("three_upper", board_out[31:16], 32'h0);

    do_reset();
    run("over", 32'h0000_0040, 32'h0000_0040, 0, 1);
    @(negedge clka);
    touched = 1'b1;
    @(negedge clka);
    touched = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clka); if (board_valid) cnt++; end
    check("over_no_resp", cnt, 0);
    check("over_sticky", game_over, 1);
    check("over_hold", board_out, 32'h0000_0040);
    check("over_busy", busy, 0);

    // restart in the middle of a scan
    do_reset();
    @(negedge clka);
    board_in = 32'hF000_0000; touched = 1'b1;
    @(posedge clka);
    #1 touched = 1'b0; board_in = '0;
    repeat (3) @(negedge clka);
    restart = 1'b1;
    #1 check_zero("midscan");
    @(negedge clka);
    restart = 1'b0;
    lfsr_m = 4'b1001; type_m = 2'b00; lines_m = 0;
    run("after_rst", 32'h0, 32'h0, 0, 0);
    check("after_rst_type", spawn_type, 2'b01);

    do_reset();
    run("seq1", 32'h0, 32'h0, 0, 0);
    run("seq2", 32'h0, 32'h0, 0, 0);
    check("seq2_type", spawn_type, 2'b11);
    run("seq3", 32'h0, 32'h0, 0, 0);
    check("seq3_type", spawn_type, 2'b10);

    // touched held high while busy
    do_reset();
    @(negedge clka);
    touched = 1'b1;
    cnt = 0; n = 0;
    while (n < 40 && cnt == 0) begin
      @(negedge clka);
      if (board_valid) cnt++;
      n++;
    end
    touched = 1'b0;
    repeat (20) begin @(negedge clka); if (board_valid) cnt++; end
    check("held_count", cnt, 1);
    check("held_board", board_out, 32'h0000_0022);

    // worst-case latency and line counter saturation
    do_reset();
    for (int k = 0; k < 32; k++) run("full", 32'hFFFF_FFFF, 32'h0, 8, 0);
    check("sat_lines", lines, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
